// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding, FSM states
// and decode helpers used by the unit, its sub-module and the hazard logic.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Any instruction that touches HI/LO must wait for an in-flight op to finish.
  function automatic logic is_md_class(input mdu_op_e op);
    return (op != MDU_NONE) && (op <= MDU_MTLO);
  endfunction

  function automatic logic is_start_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic [31:0] A;
  logic [31:0] B;
  mdu_op_e     MDUop;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  modport master (output A, B, MDUop, input Start, Busy, HI, LO, MDOut);
  modport slave  (input A, B, MDUop, output Start, Busy, HI, LO, MDOut);

endinterface

// File: rtl/mult_div_unit_compute.sv
// Combinational 32x32 multiply and divide producing the HI/LO values that the
// unit parks in its pending registers at Start.
module mult_div_unit_compute
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  mdu_op_e     op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, divisor;
  logic        [31:0] quot_u, rem_u, quot, rem;

  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Divide on magnitudes; 0x80000000 / -1 then falls out as 0x80000000 rem 0.
    a_neg   = (op_i == MDU_DIV) && a_i[31];
    b_neg   = (op_i == MDU_DIV) && b_i[31];
    a_mag   = a_neg ? (32'd0 - a_i) : a_i;
    b_mag   = b_neg ? (32'd0 - b_i) : b_i;
    divisor = (b_i == 32'd0) ? 32'd1 : b_mag;
    quot_u  = a_mag / divisor;
    rem_u   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - quot_u) : quot_u;
    rem     = a_neg ? (32'd0 - rem_u) : rem_u;

    hi_o = 32'd0;
    lo_o = 32'd0;
    wr_o = 1'b0;
    case (op_i)
      MDU_MULT: begin
        hi_o = prod_s[63:32];
        lo_o = prod_s[31:0];
        wr_o = 1'b1;
      end
      MDU_MULTU: begin
        hi_o = prod_u[63:32];
        lo_o = prod_u[31:0];
        wr_o = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        hi_o = rem;
        lo_o = quot;
        wr_o = (b_i != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/DIV ops for a fixed number
// of busy cycles and serves MFHI/MFLO/MTHI/MTLO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      hi_pend_q, lo_pend_q;
  logic             pend_wr_q;

  logic             start;
  logic [31:0]      comp_hi, comp_lo;
  logic             comp_wr;

  mult_div_unit_compute u_compute (
    .a_i  (bus.A),
    .b_i  (bus.B),
    .op_i (bus.MDUop),
    .hi_o (comp_hi),
    .lo_o (comp_lo),
    .wr_o (comp_wr)
  );

  assign start = is_start_op(bus.MDUop) && (state_q == ST_IDLE);
  assign cnt_d = is_div_op(bus.MDUop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_pend_q <= 32'd0;
      lo_pend_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= cnt_d;
            hi_pend_q <= comp_hi;
            lo_pend_q <= comp_lo;
            pend_wr_q <= comp_wr;
          end else if (bus.MDUop == MDU_MTHI) begin
            hi_q <= bus.A;
          end else if (bus.MDUop == MDU_MTLO) begin
            lo_q <= bus.A;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            // A divide by zero still burns the full period but leaves HI/LO alone.
            if (pend_wr_q) begin
              hi_q <= hi_pend_q;
              lo_q <= lo_pend_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Start = start;
  assign bus.Busy  = busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

  always_comb begin
    bus.MDOut = 32'd0;
    if (!busy_q) begin
      if (bus.MDUop == MDU_MFHI)      bus.MDOut = hi_q;
      else if (bus.MDUop == MDU_MFLO) bus.MDOut = lo_q;
    end
  end

  // The hazard unit must hold every MD-class instruction in D while busy.
  a_no_op_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(busy_q && (bus.MDUop != MDU_NONE)));

endmodule
